// File: rtl/cu_pkg.sv
// Shared encodings for control_unit_v2: opcodes, FSM states and ALU operations.
package cu_pkg;

   localparam logic [2:0] OP_MV   = 3'd0;
   localparam logic [2:0] OP_MVI  = 3'd1;
   localparam logic [2:0] OP_ADD  = 3'd2;
   localparam logic [2:0] OP_SUB  = 3'd3;
   localparam logic [2:0] OP_AND  = 3'd4;
   localparam logic [2:0] OP_MVNZ = 3'd5;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      T1   = 2'd1,
      T2   = 2'd2,
      T3   = 2'd3
   } state_t;

endpackage

// File: rtl/reg_sel_decoder.sv
// Register-select decoder: one-hot output, all-zero when disabled or sel >= N.
module reg_sel_decoder #(
   parameter int N     = 8,
   parameter int SEL_W = 3
) (
   input  logic             en,
   input  logic [SEL_W-1:0] sel,
   output logic [N-1:0]     onehot
);

   // Compare sel against each legal index so out-of-range selects match nothing
   always_comb begin
      onehot = {N{1'b0}};
      for (int i = 0; i < N; i++) begin
         if (en && (sel == SEL_W'(i))) begin
            onehot[i] = 1'b1;
         end else begin
            onehot[i] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/control_unit_v2.sv
// Multi-cycle controller for the register-file datapath: mv, mvi, add, sub, and, mvnz.
// Outputs are combinational in state, IR and Gnz; Reset forces every output low.
module control_unit_v2
   import cu_pkg::*;
#(
   parameter  int NREGS  = 8,
   localparam int RSEL_W = $clog2(NREGS),
   localparam int IR_W   = 3 + 2 * RSEL_W
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             Run,
   input  logic [IR_W-1:0]  IR,
   input  logic             Gnz,
   output logic             IRin,
   output logic [NREGS-1:0] Rin,
   output logic [NREGS-1:0] Rout,
   output logic             DINout,
   output logic             Ain,
   output logic             Gin,
   output logic             Gout,
   output logic [1:0]       ALUop,
   output logic             Done,
   output logic             Err
);

   state_t            state_r;
   state_t            state_nxt_s;
   logic [2:0]        opcode_s;
   logic [RSEL_W-1:0] rx_s;
   logic [RSEL_W-1:0] ry_s;
   logic              rx_ok_s;
   logic              ry_ok_s;
   logic              legal_s;
   logic              irin_s;
   logic              rin_s;
   logic              rout_rx_s;
   logic              rout_ry_s;
   logic              dinout_s;
   logic              ain_s;
   logic              gin_s;
   logic              gout_s;
   logic              done_s;
   logic              err_s;
   logic [1:0]        aluop_s;
   logic [NREGS-1:0]  rx_oh_s;
   logic [NREGS-1:0]  ry_oh_s;

   assign opcode_s = IR[IR_W-1 -: 3];
   assign rx_s     = IR[2*RSEL_W-1 -: RSEL_W];
   assign ry_s     = IR[RSEL_W-1:0];
   assign rx_ok_s  = (32'(rx_s) < NREGS);
   assign ry_ok_s  = (32'(ry_s) < NREGS);

   // Legality: only the register fields an opcode actually uses are range-checked
   always_comb begin
      legal_s = 1'b0;
      case (opcode_s)
         OP_MVI:                       legal_s = rx_ok_s;
         OP_MV, OP_MVNZ,
         OP_ADD, OP_SUB, OP_AND:       legal_s = rx_ok_s && ry_ok_s;
         default:                      legal_s = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (Reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and raw control decode
   always_comb begin
      state_nxt_s = state_r;
      irin_s      = 1'b0;
      rin_s       = 1'b0;
      rout_rx_s   = 1'b0;
      rout_ry_s   = 1'b0;
      dinout_s    = 1'b0;
      ain_s       = 1'b0;
      gin_s       = 1'b0;
      gout_s      = 1'b0;
      done_s      = 1'b0;
      err_s       = 1'b0;
      aluop_s     = ALU_ADD;
      case (state_r)
         IDLE: begin
            irin_s = Run;
            if (Run) begin
               state_nxt_s = T1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         T1: begin
            state_nxt_s = IDLE;
            if (!legal_s) begin
               done_s = 1'b1;
               err_s  = 1'b1;
            end else begin
               case (opcode_s)
                  OP_MV: begin
                     rout_ry_s = 1'b1;
                     rin_s     = 1'b1;
                     done_s    = 1'b1;
                  end
                  OP_MVI: begin
                     dinout_s = 1'b1;
                     rin_s    = 1'b1;
                     done_s   = 1'b1;
                  end
                  OP_MVNZ: begin
                     done_s = 1'b1;
                     if (Gnz) begin
                        rout_ry_s = 1'b1;
                        rin_s     = 1'b1;
                     end else begin
                        rout_ry_s = 1'b0;
                        rin_s     = 1'b0;
                     end
                  end
                  OP_ADD, OP_SUB, OP_AND: begin
                     rout_rx_s   = 1'b1;
                     ain_s       = 1'b1;
                     state_nxt_s = T2;
                  end
                  default: begin
                     done_s = 1'b1;
                     err_s  = 1'b1;
                  end
               endcase
            end
         end
         T2: begin
            rout_ry_s   = 1'b1;
            gin_s       = 1'b1;
            state_nxt_s = T3;
            case (opcode_s)
               OP_SUB:  aluop_s = ALU_SUB;
               OP_AND:  aluop_s = ALU_AND;
               default: aluop_s = ALU_ADD;
            endcase
         end
         T3: begin
            gout_s      = 1'b1;
            rin_s       = 1'b1;
            done_s      = 1'b1;
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   reg_sel_decoder #(.N(NREGS), .SEL_W(RSEL_W)) u_rx_dec (
      .en     (rin_s | rout_rx_s),
      .sel    (rx_s),
      .onehot (rx_oh_s)
   );

   reg_sel_decoder #(.N(NREGS), .SEL_W(RSEL_W)) u_ry_dec (
      .en     (rout_ry_s),
      .sel    (ry_s),
      .onehot (ry_oh_s)
   );

   // rx decoder serves both Rin and the ALU-T1 Rout, so each use is gated by its own strobe
   assign Rin    = (rin_s && !Reset) ? rx_oh_s : {NREGS{1'b0}};
   assign Rout   = Reset ? {NREGS{1'b0}} : (rout_rx_s ? rx_oh_s : ry_oh_s);
   assign IRin   = irin_s   & ~Reset;
   assign DINout = dinout_s & ~Reset;
   assign Ain    = ain_s    & ~Reset;
   assign Gin    = gin_s    & ~Reset;
   assign Gout   = gout_s   & ~Reset;
   assign ALUop  = Reset ? ALU_ADD : aluop_s;
   assign Done   = done_s   & ~Reset;
   assign Err    = err_s    & ~Reset;

endmodule

// File: tb/tb_control_unit_v2.sv
// Bench for control_unit_v2: table of per-cycle vectors through a scoreboard queue,
// plus a hand-written back-to-back sequence; NREGS=8 and NREGS=6 instances in lockstep.
module tb_control_unit_v2;

   logic       clk = 1'b0;
   logic       Reset = 1'b1;
   logic       Run = 1'b0;
   logic       Gnz = 1'b0;
   logic [8:0] ir = 9'h000;

   logic       irin8, din8, ain8, gin8, gout8, done8, err8;
   logic [7:0] rin8, rout8;
   logic [1:0] alu8;
   logic       irin6, din6, ain6, gin6, gout6, done6, err6;
   logic [5:0] rin6, rout6;
   logic [1:0] alu6;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic        rst;
      logic        run;
      logic        gnz;
      logic        sel;
      logic [8:0]  ir;
      logic [40:0] exp;
   } vec_t;

   typedef struct {
      int          idx;
      logic        sel;
      logic [40:0] exp;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb_q[$];

   always #5 clk = ~clk;

   control_unit_v2 #(.NREGS(8)) u8 (
      .clk(clk), .Reset(Reset), .Run(Run), .IR(ir), .Gnz(Gnz),
      .IRin(irin8), .Rin(rin8), .Rout(rout8), .DINout(din8), .Ain(ain8),
      .Gin(gin8), .Gout(gout8), .ALUop(alu8), .Done(done8), .Err(err8)
   );

   control_unit_v2 #(.NREGS(6)) u6 (
      .clk(clk), .Reset(Reset), .Run(Run), .IR(ir), .Gnz(Gnz),
      .IRin(irin6), .Rin(rin6), .Rout(rout6), .DINout(din6), .Ain(ain6),
      .Gin(gin6), .Gout(gout6), .ALUop(alu6), .Done(done6), .Err(err6)
   );

   function automatic logic [8:0] ins(input int op, input int rx, input int ry);
      return {op[2:0], rx[2:0], ry[2:0]};
   endfunction

   function automatic logic [40:0] e(input logic irin, input logic [15:0] rin,
                                     input logic [15:0] rout, input logic din,
                                     input logic ain, input logic gin, input logic gout,
                                     input logic [1:0] alu, input logic done, input logic err);
      return {irin, rin, rout, din, ain, gin, gout, alu, done, err};
   endfunction

   task automatic addv(input logic rst, input logic run, input logic gnz,
                       input logic sel, input logic [8:0] i, input logic [40:0] x);
      vec_t v;
      v.rst = rst; v.run = run; v.gnz = gnz; v.sel = sel; v.ir = i; v.exp = x;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Scoreboard: pop the expectation pushed with this cycle's stimulus and compare
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         sb_t s;
         logic [40:0] act;
         s = sb_q.pop_front();
         if (s.sel) begin
            act = e(irin6, 16'(rin6), 16'(rout6), din6, ain6, gin6, gout6, alu6, done6, err6);
         end else begin
            act = e(irin8, 16'(rin8), 16'(rout8), din8, ain8, gin8, gout8, alu8, done8, err8);
         end
         chk($sformatf("vec%0d", s.idx), 64'(act), 64'(s.exp));
      end
   end

   initial begin
      logic [40:0] z, irq, mv25, a_t1, a_t3, bad;
      int irc[$];
      int dnc[$];
      int irc_exp[3];
      int dnc_exp[3];

      z    = 41'h0;
      irq  = e(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      mv25 = e(1'b0, 16'h0004, 16'h0020, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
      a_t1 = e(1'b0, 16'h0000, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      a_t3 = e(1'b0, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0);
      bad  = e(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);

      // reset state, Run masked while Reset is high
      addv(1'b1, 1'b0, 1'b0, 1'b0, ins(0, 2, 5), z);
      addv(1'b1, 1'b1, 1'b0, 1'b0, ins(0, 2, 5), z);
      addv(1'b0, 1'b0, 1'b0, 1'b0, ins(0, 2, 5), z);
      // mv r2,r5
      addv(1'b0, 1'b1, 1'b0, 1'b0, ins(0, 2, 5), irq);
      addv(1'b0, 1'b0, 1'b0, 1'b0, ins(0, 2, 5), mv25);
      addv(1'b0, 1'b0, 1'b0, 1'b0, ins(0, 2, 5), z);
      // add / sub / and r1,r3
      for (int k = 0; k < 3; k++) begin
         addv(1'b0, 1'b1, 1'b0, 1'b0, ins(2 + k, 1, 3), irq);
         addv(1'b0, 1'b0, 1'b0, 1'b0, ins(2 + k, 1, 3), a_t1);
         addv(1'b0, 1'b0, 1'b0, 1'b0, ins(2 + k, 1, 3),
              e(1'b0, 16'h0000, 16'h0008, 1'b0, 1'b0, 1'b1, 1'b0, k[1:0], 1'b0, 1'b0));
         addv(1'b0, 1'b0, 1'b0, 1'b0, ins(2 + k, 1, 3), a_t3);
      end
      // mvnz r0,r7 with Gnz=0 then Gnz=1
      addv(1'b0, 1'b1, 1'b0, 1'b0, ins(5, 0, 7), irq);
      addv(1'b0, 1'b0, 1'b0, 1'b0, ins(5, 0, 7),
           e(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0));
      addv(1'b0, 1'b1, 1'b1, 1'b0, ins(5, 0, 7), irq);
      addv(1'b0, 1'b0, 1'b1, 1'b0, ins(5, 0, 7),
           e(1'b0, 16'h0001, 16'h0080, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0));
      // illegal opcodes 6 and 7
      addv(1'b0, 1'b1, 1'b0, 1'b0, ins(6, 1, 2), irq);
      addv(1'b0, 1'b0, 1'b0, 1'b0, ins(6, 1, 2), bad);
      addv(1'b0, 1'b1, 1'b1, 1'b0, ins(7, 3, 4), irq);
      addv(1'b0, 1'b0, 1'b1, 1'b0, ins(7, 3, 4), bad);
      // mvi r4
      addv(1'b0, 1'b1, 1'b0, 1'b0, ins(1, 4, 7), irq);
      addv(1'b0, 1'b0, 1'b0, 1'b0, ins(1, 4, 7),
           e(1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0));
      // Reset during T2 of add, then restart; Run in T1 ignored
      addv(1'b0, 1'b1, 1'b0, 1'b0, ins(2, 1, 3), irq);
      addv(1'b0, 1'b0, 1'b0, 1'b0, ins(2, 1, 3), a_t1);
      addv(1'b1, 1'b0, 1'b0, 1'b0, ins(2, 1, 3), z);
      addv(1'b0, 1'b0, 1'b0, 1'b0, ins(2, 1, 3), z);
      addv(1'b0, 1'b1, 1'b0, 1'b0, ins(0, 2, 5), irq);
      addv(1'b0, 1'b1, 1'b0, 1'b0, ins(0, 2, 5), mv25);
      addv(1'b0, 1'b0, 1'b0, 1'b0, ins(0, 2, 5), z);
      // NREGS=6 range checks
      addv(1'b0, 1'b1, 1'b0, 1'b1, ins(0, 6, 1), irq);
      addv(1'b0, 1'b0, 1'b0, 1'b1, ins(0, 6, 1), bad);
      addv(1'b0, 1'b1, 1'b0, 1'b1, ins(0, 1, 6), irq);
      addv(1'b0, 1'b0, 1'b0, 1'b1, ins(0, 1, 6), bad);
      addv(1'b0, 1'b1, 1'b0, 1'b1, ins(1, 5, 7), irq);
      addv(1'b0, 1'b0, 1'b0, 1'b1, ins(1, 5, 7),
           e(1'b0, 16'h0020, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0));
      addv(1'b0, 1'b1, 1'b0, 1'b1, ins(2, 6, 1), irq);
      addv(1'b0, 1'b0, 1'b0, 1'b1, ins(2, 6, 1), bad);
      addv(1'b0, 1'b1, 1'b0, 1'b1, ins(5, 2, 4), irq);
      addv(1'b0, 1'b0, 1'b1, 1'b1, ins(5, 2, 4),
           e(1'b0, 16'h0004, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0));

      foreach (vecs[i]) begin
         sb_t s;
         @(posedge clk);
         #1;
         Reset = vecs[i].rst;
         Run   = vecs[i].run;
         Gnz   = vecs[i].gnz;
         ir    = vecs[i].ir;
         s.idx = i; s.sel = vecs[i].sel; s.exp = vecs[i].exp;
         sb_q.push_back(s);
      end

      // Run held high: mvi then add twice, plus a Run pulse in T2 of the last add
      irc_exp = '{0, 2, 6};
      dnc_exp = '{1, 5, 9};
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1;
         Reset = 1'b0;
         Gnz   = 1'b0;
         Run   = (c <= 6) || (c == 8);
         ir    = (c < 2) ? ins(1, 4, 0) : ins(2, 1, 3);
         @(negedge clk);
         if (irin8) irc.push_back(c);
         if (done8) dnc.push_back(c);
      end
      chk("irin_count", 64'(irc.size()), 64'd3);
      chk("done_count", 64'(dnc.size()), 64'd3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("irin_cycle%0d", i), 64'(i < irc.size() ? irc[i] : -1), 64'(irc_exp[i]));
         chk($sformatf("done_cycle%0d", i), 64'(i < dnc.size() ? dnc[i] : -1), 64'(dnc_exp[i]));
      end
      chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
